control_unit: RTL and testbench
===============================

// Module: control_unit
// PURPOSE
//  Multi-cycle sequencer that drives the ALU and register file of the 8-bit processor. Fetches
//  32-bit instructions over a REQ/VALID handshake, decodes them, and issues ALU SELECT codes,
//  register addresses and write enables. Consumes the ALU ZERO flag and updates PC (beq/j).
// PARAMETERS
//  PC_WIDTH   32  width of PC; arithmetic wraps modulo 2^PC_WIDTH
//  RESET_PC   0   PC value loaded on reset
//  REG_AW     3   register address width (8 registers)
// PORTS
//  CLK          in   1   rising-edge clock
//  RESET        in   1   asynchronous, active-high reset
//  PC           out  PC_WIDTH  address of instruction being fetched/executed
//  INSTR_REQ    out  1   fetch request, high only in FETCH
//  INSTR_VALID  in   1   INSTRUCTION valid; sampled only in FETCH
//  INSTRUCTION  in   32  [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/imm
//  READREG1     out  REG_AW  = INSTRUCTION[10:8] (latched)
//  READREG2     out  REG_AW  = INSTRUCTION[2:0] (latched)
//  WRITEREG     out  REG_AW  = INSTRUCTION[18:16] (latched)
//  WRITEENABLE  out  1   register-file write strobe, one cycle in WB
//  ALUOP        out  3   ALU SELECT: 000 fwd, 001 add, 010 and, 011 or; never 1xx
//  NEG_SEL      out  1   operand-2 two's-complement select (sub, beq)
//  IMM_SEL      out  1   operand-2 = IMMEDIATE instead of register (loadi)
//  IMMEDIATE    out  8   = INSTRUCTION[7:0] (latched)
//  ZERO         in   1   ALU zero flag; sampled at end of EXEC
//  ILLEGAL      out  1   one-cycle pulse in WB for an undefined opcode
// BEHAVIOUR
//  Reset (async): state=IDLE, PC=RESET_PC, IR=0, all other outputs 0, including WRITEENABLE
//   immediately, even if RESET asserts mid-instruction. No partial write or PC update survives.
//  FSM: IDLE->FETCH (1 cycle after reset release); FETCH->DECODE on edge with INSTR_VALID=1,
//   IR<=INSTRUCTION, else stay in FETCH; DECODE->EXEC->WB->FETCH unconditionally.
//   Minimum 4 cycles/instr.
//  INSTR_VALID outside FETCH is ignored. INSTRUCTION may change freely outside the capture edge.
//  DECODE: registered control word from IR (READREG*, WRITEREG, ALUOP, NEG_SEL, IMM_SEL,
//   IMMEDIATE). These are held stable through EXEC and WB.
//  Opcodes: 0 loadi(fwd,IMM_SEL) 1 mov(fwd) 2 add(add) 3 sub(add,NEG_SEL) 4 and 5 or
//   6 j (no ALU use, ALUOP=000) 7 beq(add,NEG_SEL). Others are illegal: treated as NOP.
//  EXEC: combinational regfile read + ALU settle; ZERO registered at the EXEC->WB edge.
//  WB: WRITEENABLE=1 for exactly one cycle for opcodes 0-5; 0 for j/beq/illegal.
//  PC update at WB->FETCH edge. Default PC+4.
//   j: PC+4+(sext(IR[23:16])<<2).
//   beq with ZERO=1: same target; with ZERO=0: PC+4.
//  Offset is 8-bit signed (-128..127 words). Target wraps modulo 2^PC_WIDTH, no overflow flag.
//  ILLEGAL is high for the WB cycle of an undefined opcode only; PC still advances by 4.
//  PC is stable from FETCH entry until the WB->FETCH edge.
// STRUCTURE
//  Shared package cpu_pkg holds:
//   opcode constants OP_LOADI..OP_BEQ;
//   ALU select constants ALU_FWD=3'b000, ALU_ADD=3'b001, ALU_AND=3'b010, ALU_OR=3'b011;
//   state encoding IDLE/FETCH/DECODE/EXEC/WB;
//   instruction field bit positions.
//  One sub-module: instr_decoder, purely combinational, opcode -> {ALUOP, NEG_SEL, IMM_SEL,
//  REG_WRITE, IS_JUMP, IS_BEQ, ILLEGAL}. Registered by control_unit in DECODE.
// TESTING
//  Reset: assert RESET mid-EXEC of add -> outputs 0 same cycle; PC=0; no WRITEENABLE;
//   INSTR_REQ high 1 cycle after release.
//  loadi r2,#0x05 (0x00020005), VALID after 3 stall cycles -> REQ held with PC=0;
//   IMM_SEL=1, ALUOP=000, WRITEREG=2, IMMEDIATE=0x05; 1-cycle WRITEENABLE; PC=4.
//  sub r3,r1,r2 (0x03030102) -> ALUOP=001, NEG_SEL=1, READREG1=1, READREG2=2, WRITEREG=3.
//   Sequence and/or: ALUOP 010/011.
//  beq -2,r1,r2 at PC=8 (0x07FE0102): ZERO=1 -> PC=4; ZERO=0 -> PC=12; no WRITEENABLE.
//  j +1 at PC=0xFFFFFFFC (0x06010000) -> PC wraps to 0x00000004.
//  Opcode 0xFF -> ILLEGAL pulse in WB, WRITEENABLE=0, PC+4; ALUOP never 1xx in any cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor control path: opcodes, ALU selects,
// sequencer states, instruction field positions and the decoded control word.
package cpu_pkg;

    localparam logic [7:0] OP_LOADI = 8'h00;
    localparam logic [7:0] OP_MOV   = 8'h01;
    localparam logic [7:0] OP_ADD   = 8'h02;
    localparam logic [7:0] OP_SUB   = 8'h03;
    localparam logic [7:0] OP_AND   = 8'h04;
    localparam logic [7:0] OP_OR    = 8'h05;
    localparam logic [7:0] OP_J     = 8'h06;
    localparam logic [7:0] OP_BEQ   = 8'h07;

    localparam logic [2:0] ALU_FWD = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam int OPC_MSB  = 31;
    localparam int OPC_LSB  = 24;
    localparam int DST_MSB  = 23;
    localparam int DST_LSB  = 16;
    localparam int SRC1_MSB = 15;
    localparam int SRC1_LSB = 8;
    localparam int SRC2_MSB = 7;
    localparam int SRC2_LSB = 0;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4
    } state_t;

    typedef struct packed {
        logic [2:0] aluop;
        logic       neg_sel;
        logic       imm_sel;
        logic       reg_write;
        logic       is_jump;
        logic       is_beq;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        aluop:     ALU_FWD,
        neg_sel:   1'b0,
        imm_sel:   1'b0,
        reg_write: 1'b0,
        is_jump:   1'b0,
        is_beq:    1'b0,
        illegal:   1'b0
    };

    // A jump always redirects; a beq redirects only when the ALU saw equal operands.
    function automatic logic branch_taken(input ctrl_t c, input logic zero);
        return c.is_jump | (c.is_beq & zero);
    endfunction

endpackage

// File: rtl/control_unit_instr_decoder.sv
// Purely combinational opcode decoder; undefined opcodes decode to a NOP with
// the illegal flag set.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [7:0] i_opcode,
    output logic [2:0] o_aluop,
    output logic       o_neg_sel,
    output logic       o_imm_sel,
    output logic       o_reg_write,
    output logic       o_is_jump,
    output logic       o_is_beq,
    output logic       o_illegal
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = CTRL_NOP;
        case (i_opcode)
            OP_LOADI: begin
                w_ctrl.aluop     = ALU_FWD;
                w_ctrl.imm_sel   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OP_MOV: begin
                w_ctrl.aluop     = ALU_FWD;
                w_ctrl.reg_write = 1'b1;
            end
            OP_ADD: begin
                w_ctrl.aluop     = ALU_ADD;
                w_ctrl.reg_write = 1'b1;
            end
            OP_SUB: begin
                w_ctrl.aluop     = ALU_ADD;
                w_ctrl.neg_sel   = 1'b1;
                w_ctrl.reg_write = 1'b1;
            end
            OP_AND: begin
                w_ctrl.aluop     = ALU_AND;
                w_ctrl.reg_write = 1'b1;
            end
            OP_OR: begin
                w_ctrl.aluop     = ALU_OR;
                w_ctrl.reg_write = 1'b1;
            end
            OP_J: begin
                w_ctrl.aluop     = ALU_FWD;
                w_ctrl.is_jump   = 1'b1;
            end
            OP_BEQ: begin
                w_ctrl.aluop     = ALU_ADD;
                w_ctrl.neg_sel   = 1'b1;
                w_ctrl.is_beq    = 1'b1;
            end
            default: begin
                w_ctrl.illegal   = 1'b1;
            end
        endcase
    end

    assign o_aluop     = w_ctrl.aluop;
    assign o_neg_sel   = w_ctrl.neg_sel;
    assign o_imm_sel   = w_ctrl.imm_sel;
    assign o_reg_write = w_ctrl.reg_write;
    assign o_is_jump   = w_ctrl.is_jump;
    assign o_is_beq    = w_ctrl.is_beq;
    assign o_illegal   = w_ctrl.illegal;

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer (IDLE/FETCH/DECODE/EXEC/WB) driving the ALU and register
// file; every output is a register so nothing glitches into the datapath.
module control_unit
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter int                  REG_AW   = 3
) (
    input  logic                i_clk,
    input  logic                i_reset,
    output logic [PC_WIDTH-1:0] o_pc,
    output logic                o_instr_req,
    input  logic                i_instr_valid,
    input  logic [31:0]         i_instruction,
    output logic [REG_AW-1:0]   o_readreg1,
    output logic [REG_AW-1:0]   o_readreg2,
    output logic [REG_AW-1:0]   o_writereg,
    output logic                o_writeenable,
    output logic [2:0]          o_aluop,
    output logic                o_neg_sel,
    output logic                o_imm_sel,
    output logic [7:0]          o_immediate,
    input  logic                i_zero,
    output logic                o_illegal
);

    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(32'd4);

    state_t              r_state;
    state_t              w_next_state;
    logic [31:0]         r_ir;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_seq;
    logic [PC_WIDTH-1:0] w_pc_next;
    logic [PC_WIDTH-1:0] w_offset;
    ctrl_t               r_ctrl;
    ctrl_t               w_dec;
    logic [REG_AW-1:0]   r_rr1;
    logic [REG_AW-1:0]   r_rr2;
    logic [REG_AW-1:0]   r_wr;
    logic [7:0]          r_imm;
    logic                r_zero;
    logic                r_req;
    logic                r_we;
    logic                r_ill;
    logic                w_unused_src1_hi;

    assign w_unused_src1_hi = ^r_ir[SRC1_MSB:SRC1_LSB+REG_AW];

    instr_decoder u_decoder (
        .i_opcode    (r_ir[OPC_MSB:OPC_LSB]),
        .o_aluop     (w_dec.aluop),
        .o_neg_sel   (w_dec.neg_sel),
        .o_imm_sel   (w_dec.imm_sel),
        .o_reg_write (w_dec.reg_write),
        .o_is_jump   (w_dec.is_jump),
        .o_is_beq    (w_dec.is_beq),
        .o_illegal   (w_dec.illegal)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    w_next_state = FETCH;
            FETCH: begin
                if (i_instr_valid) begin
                    w_next_state = DECODE;
                end else begin
                    w_next_state = FETCH;
                end
            end
            DECODE:  w_next_state = EXEC;
            EXEC:    w_next_state = WB;
            WB:      w_next_state = FETCH;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ir <= 32'h0000_0000;
        end else if (r_state == FETCH && i_instr_valid) begin
            r_ir <= i_instruction;
        end
    end

    // Control word is captured once in DECODE and held through EXEC and WB.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ctrl <= CTRL_NOP;
            r_rr1  <= '0;
            r_rr2  <= '0;
            r_wr   <= '0;
            r_imm  <= 8'h00;
        end else if (r_state == DECODE) begin
            r_ctrl <= w_dec;
            r_rr1  <= r_ir[SRC1_LSB +: REG_AW];
            r_rr2  <= r_ir[SRC2_LSB +: REG_AW];
            r_wr   <= r_ir[DST_LSB +: REG_AW];
            r_imm  <= r_ir[SRC2_MSB:SRC2_LSB];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_req  <= 1'b0;
            r_we   <= 1'b0;
            r_ill  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            r_req <= (w_next_state == FETCH);
            r_we  <= (r_state == EXEC) & r_ctrl.reg_write;
            r_ill <= (r_state == EXEC) & r_ctrl.illegal;
            if (r_state == EXEC) begin
                r_zero <= i_zero;
            end
        end
    end

    // Branch offset is a signed word count, so scale by 4 after sign extension.
    always_comb begin
        w_offset = {{(PC_WIDTH-10){r_ir[DST_MSB]}}, r_ir[DST_MSB:DST_LSB], 2'b00};
        w_pc_seq = r_pc + PC_STEP;
        if (branch_taken(r_ctrl, r_zero)) begin
            w_pc_next = w_pc_seq + w_offset;
        end else begin
            w_pc_next = w_pc_seq;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
        end else if (r_state == WB) begin
            r_pc <= w_pc_next;
        end
    end

    assign o_pc          = r_pc;
    assign o_instr_req   = r_req;
    assign o_readreg1    = r_rr1;
    assign o_readreg2    = r_rr2;
    assign o_writereg    = r_wr;
    assign o_writeenable = r_we;
    assign o_aluop       = r_ctrl.aluop;
    assign o_neg_sel     = r_ctrl.neg_sel;
    assign o_imm_sel     = r_ctrl.imm_sel;
    assign o_immediate   = r_imm;
    assign o_illegal     = r_ill;

endmodule

// File: tb/tb_control_unit.sv
// Directed, table-driven bench for control_unit with hand-computed expectations.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc;
    logic        req;
    logic        valid = 1'b0;
    logic [31:0] instr = 32'h0;
    logic [2:0]  rr1, rr2, wr;
    logic        we;
    logic [2:0]  aluop;
    logic        neg_sel, imm_sel;
    logic [7:0]  imm;
    logic        zero = 1'b0;
    logic        ill;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    control_unit dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .o_pc          (pc),
        .o_instr_req   (req),
        .i_instr_valid (valid),
        .i_instruction (instr),
        .o_readreg1    (rr1),
        .o_readreg2    (rr2),
        .o_writereg    (wr),
        .o_writeenable (we),
        .o_aluop       (aluop),
        .o_neg_sel     (neg_sel),
        .o_imm_sel     (imm_sel),
        .o_immediate   (imm),
        .i_zero        (zero),
        .o_illegal     (ill)
    );

    typedef struct {
        string       name;
        logic [31:0] instr;
        int          stall;
        logic        zero;
        logic [31:0] pc;
        logic [2:0]  aluop;
        logic        neg;
        logic        imm_sel;
        logic [2:0]  rr1;
        logic [2:0]  rr2;
        logic [2:0]  wr;
        logic [7:0]  imm;
        logic        we;
        logic        ill;
        logic [31:0] npc;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc"},    pc, 32'h0);
        check({tag, "_req"},   {31'h0, req}, 32'h0);
        check({tag, "_we"},    {31'h0, we}, 32'h0);
        check({tag, "_ill"},   {31'h0, ill}, 32'h0);
        check({tag, "_ctrl"},  {16'h0, aluop, neg_sel, imm_sel, rr1, rr2, wr}, 32'h0);
        check({tag, "_imm"},   {24'h0, imm}, 32'h0);
    endtask

    // Waits (bounded) for a fetch request, stalls, delivers the word, ends in EXEC.
    task automatic fetch_to_exec(input vec_t v);
        int k;
        k = 0;
        while (req !== 1'b1 && k < 10) begin
            step();
            k++;
        end
        check({v.name, "_req_wait"}, {31'h0, req}, 32'h1);
        check({v.name, "_fetch_pc"}, pc, v.pc);
        for (int i = 0; i < v.stall; i++) begin
            valid = 1'b0;
            instr = $urandom;
            step();
            check({v.name, "_stall_req"}, {31'h0, req}, 32'h1);
            check({v.name, "_stall_pc"}, pc, v.pc);
        end
        instr = v.instr;
        valid = 1'b1;
        zero  = ~v.zero;
        step();
        valid = 1'b0;
        instr = $urandom;
        check({v.name, "_dec_req"}, {31'h0, req}, 32'h0);
        check({v.name, "_dec_pc"}, pc, v.pc);
        step();
        check({v.name, "_aluop"},   {29'h0, aluop}, {29'h0, v.aluop});
        check({v.name, "_neg"},     {31'h0, neg_sel}, {31'h0, v.neg});
        check({v.name, "_immsel"},  {31'h0, imm_sel}, {31'h0, v.imm_sel});
        check({v.name, "_rr1"},     {29'h0, rr1}, {29'h0, v.rr1});
        check({v.name, "_rr2"},     {29'h0, rr2}, {29'h0, v.rr2});
        check({v.name, "_wr"},      {29'h0, wr}, {29'h0, v.wr});
        check({v.name, "_imm"},     {24'h0, imm}, {24'h0, v.imm});
        check({v.name, "_exec_we"}, {31'h0, we}, 32'h0);
    endtask

    task automatic finish_instr(input vec_t v);
        zero  = v.zero;
        valid = 1'b1;
        instr = 32'hFFFF_FFFF;
        step();
        zero  = ~v.zero;
        valid = 1'b0;
        check({v.name, "_wb_we"},    {31'h0, we}, {31'h0, v.we});
        check({v.name, "_wb_ill"},   {31'h0, ill}, {31'h0, v.ill});
        check({v.name, "_wb_aluop"}, {29'h0, aluop}, {29'h0, v.aluop});
        check({v.name, "_wb_wr"},    {29'h0, wr}, {29'h0, v.wr});
        check({v.name, "_wb_pc"},    pc, v.pc);
        check({v.name, "_wb_req"},   {31'h0, req}, 32'h0);
        step();
        check({v.name, "_npc"},      pc, v.npc);
        check({v.name, "_f_req"},    {31'h0, req}, 32'h1);
        check({v.name, "_f_we"},     {31'h0, we}, 32'h0);
        check({v.name, "_f_ill"},    {31'h0, ill}, 32'h0);
    endtask

    initial begin
        vec_t v;
        //                name      instr         st z  pc            alu  n  i  r1 r2 wr imm    we il npc
        vecs.push_back('{"loadi",  32'h00020005, 3, 0, 32'h00000000, 3'd0, 0, 1, 0, 5, 2, 8'h05, 1, 0, 32'h00000004});
        vecs.push_back('{"sub",    32'h03030102, 0, 0, 32'h00000004, 3'd1, 1, 0, 1, 2, 3, 8'h02, 1, 0, 32'h00000008});
        vecs.push_back('{"beq_t",  32'h07FE0102, 1, 1, 32'h00000008, 3'd1, 1, 0, 1, 2, 6, 8'h02, 0, 0, 32'h00000004});
        vecs.push_back('{"and",    32'h04010203, 0, 0, 32'h00000004, 3'd2, 0, 0, 2, 3, 1, 8'h03, 1, 0, 32'h00000008});
        vecs.push_back('{"beq_n",  32'h07FE0102, 0, 0, 32'h00000008, 3'd1, 1, 0, 1, 2, 6, 8'h02, 0, 0, 32'h0000000C});
        vecs.push_back('{"or",     32'h05050607, 2, 1, 32'h0000000C, 3'd3, 0, 0, 6, 7, 5, 8'h07, 1, 0, 32'h00000010});
        vecs.push_back('{"illeg",  32'hFF000000, 0, 0, 32'h00000010, 3'd0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 32'h00000014});
        vecs.push_back('{"mov",    32'h01040300, 0, 0, 32'h00000014, 3'd0, 0, 0, 3, 0, 4, 8'h00, 1, 0, 32'h00000018});
        vecs.push_back('{"add",    32'h02070501, 1, 0, 32'h00000018, 3'd1, 0, 0, 5, 1, 7, 8'h01, 1, 0, 32'h0000001C});
        vecs.push_back('{"j_back", 32'h06F80000, 0, 0, 32'h0000001C, 3'd0, 0, 0, 0, 0, 0, 8'h00, 0, 0, 32'h00000000});
        vecs.push_back('{"j_neg",  32'h06FE0000, 0, 1, 32'h00000000, 3'd0, 0, 0, 0, 0, 6, 8'h00, 0, 0, 32'hFFFFFFFC});
        vecs.push_back('{"j_wrap", 32'h06010000, 0, 0, 32'hFFFFFFFC, 3'd0, 0, 0, 0, 0, 1, 8'h00, 0, 0, 32'h00000004});

        #1 rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        step();
        step();
        check_all_zero("rst_hold");
        rst = 1'b0;
        check_all_zero("rst_idle");
        step();
        check({"rst_rel", "_req"}, {31'h0, req}, 32'h1);
        check({"rst_rel", "_pc"}, pc, 32'h0);

        foreach (vecs[i]) begin
            fetch_to_exec(vecs[i]);
            finish_instr(vecs[i]);
        end

        // Reset lands mid-EXEC of an add: everything must clear before the edge.
        v = '{"rst_add", 32'h02070501, 0, 0, 32'h00000004, 3'd1, 0, 0, 5, 1, 7, 8'h01, 1, 0, 32'h00000008};
        fetch_to_exec(v);
        #2 rst = 1'b1;
        #1;
        check_all_zero("mid_exec");
        step();
        check_all_zero("mid_exec_edge");
        rst = 1'b0;
        step();
        check({"post_rst", "_req"}, {31'h0, req}, 32'h1);
        check({"post_rst", "_pc"}, pc, 32'h0);
        check({"post_rst", "_we"}, {31'h0, we}, 32'h0);

        v = '{"loadi2", 32'h00020005, 1, 0, 32'h00000000, 3'd0, 0, 1, 0, 5, 2, 8'h05, 1, 0, 32'h00000004};
        fetch_to_exec(v);
        finish_instr(v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // ALUOP must never select an undefined function in any cycle.
    always @(negedge clk) begin
        if (aluop[2] !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL aluop_msb: got %b expected 0xx", aluop);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
